// File: rtl/regfile_port_arbiter.sv
// Purpose: round-robin arbiter sharing one register-file command port between requesters A and B.
// Latency: response valid 3 cycles after acceptance; at most one command every 4 cycles.
// Backpressure: one command in flight; both readies stay low until the response is consumed.
module regfile_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              reqa_valid,
    output logic              reqa_ready,
    input  logic              reqa_rd,
    input  logic              reqa_wr,
    input  logic [ADDR_W-1:0] reqa_waddr,
    input  logic [DATA_W-1:0] reqa_wdata,
    input  logic [ADDR_W-1:0] reqa_raddr1,
    input  logic [ADDR_W-1:0] reqa_raddr2,

    input  logic              reqb_valid,
    output logic              reqb_ready,
    input  logic              reqb_rd,
    input  logic              reqb_wr,
    input  logic [ADDR_W-1:0] reqb_waddr,
    input  logic [DATA_W-1:0] reqb_wdata,
    input  logic [ADDR_W-1:0] reqb_raddr1,
    input  logic [ADDR_W-1:0] reqb_raddr2,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_op1,
    output logic [DATA_W-1:0] rsp_op2,

    output logic              rf_en,
    output logic              rf_rd,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_sel_i1,
    output logic [ADDR_W-1:0] rf_sel_o1,
    output logic [ADDR_W-1:0] rf_sel_o2,
    output logic [DATA_W-1:0] rf_ip1,
    input  logic [DATA_W-1:0] rf_op1,
    input  logic [DATA_W-1:0] rf_op2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    // 0 = A, 1 = B; reset to B so A wins the first tie
    logic last_grant;
    logic lat_rd;

    logic              grant_vld;
    logic              sel_b;
    logic              g_rd;
    logic              g_wr;
    logic [ADDR_W-1:0] g_waddr;
    logic [DATA_W-1:0] g_wdata;
    logic [ADDR_W-1:0] g_raddr1;
    logic [ADDR_W-1:0] g_raddr2;

    always_comb begin
        grant_vld = 1'b0;
        sel_b     = 1'b0;
        if (state == IDLE && !rst) begin
            if (reqa_valid && reqb_valid) begin
                grant_vld = 1'b1;
                sel_b     = ~last_grant;
            end else if (reqa_valid) begin
                grant_vld = 1'b1;
            end else if (reqb_valid) begin
                grant_vld = 1'b1;
                sel_b     = 1'b1;
            end
        end
        reqa_ready = grant_vld & ~sel_b;
        reqb_ready = grant_vld & sel_b;
    end

    always_comb begin
        g_rd     = sel_b ? reqb_rd     : reqa_rd;
        g_wr     = sel_b ? reqb_wr     : reqa_wr;
        g_waddr  = sel_b ? reqb_waddr  : reqa_waddr;
        g_wdata  = sel_b ? reqb_wdata  : reqa_wdata;
        g_raddr1 = sel_b ? reqb_raddr1 : reqa_raddr1;
        g_raddr2 = sel_b ? reqb_raddr2 : reqa_raddr2;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = EXEC;
            EXEC:    state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_rd     <= 1'b0;
            rf_en      <= 1'b0;
            rf_rd      <= 1'b0;
            rf_wr      <= 1'b0;
            rf_sel_i1  <= '0;
            rf_sel_o1  <= '0;
            rf_sel_o2  <= '0;
            rf_ip1     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_op1    <= '0;
            rsp_op2    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        lat_rd     <= g_rd;
                        rf_en      <= g_rd | g_wr;
                        rf_rd      <= g_rd;
                        rf_wr      <= g_wr;
                        rf_sel_i1  <= g_waddr;
                        rf_sel_o1  <= g_raddr1;
                        rf_sel_o2  <= g_raddr2;
                        rf_ip1     <= g_wdata;
                        last_grant <= sel_b;
                        rsp_id     <= sel_b;
                    end
                end
                EXEC: begin
                    rf_en <= 1'b0;
                    rf_rd <= 1'b0;
                    rf_wr <= 1'b0;
                end
                WAIT: begin
                    // register file outputs are valid one edge after it samples the command
                    rsp_op1   <= lat_rd ? rf_op1 : '0;
                    rsp_op2   <= lat_rd ? rf_op2 : '0;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural 16x32 register file attached.
module tb_regfile_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqa_valid = 1'b0, reqb_valid = 1'b0;
    logic          reqa_ready, reqb_ready;
    logic          reqa_rd = 1'b0, reqa_wr = 1'b0, reqb_rd = 1'b0, reqb_wr = 1'b0;
    logic [AW-1:0] reqa_waddr = '0, reqa_raddr1 = '0, reqa_raddr2 = '0;
    logic [AW-1:0] reqb_waddr = '0, reqb_raddr1 = '0, reqb_raddr2 = '0;
    logic [DW-1:0] reqa_wdata = '0, reqb_wdata = '0;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_op1, rsp_op2;
    logic          rf_en, rf_rd, rf_wr;
    logic [AW-1:0] rf_sel_i1, rf_sel_o1, rf_sel_o2;
    logic [DW-1:0] rf_ip1;
    logic [DW-1:0] rf_op1 = '0, rf_op2 = '0;

    regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .reqa_valid(reqa_valid), .reqa_ready(reqa_ready), .reqa_rd(reqa_rd), .reqa_wr(reqa_wr),
        .reqa_waddr(reqa_waddr), .reqa_wdata(reqa_wdata), .reqa_raddr1(reqa_raddr1), .reqa_raddr2(reqa_raddr2),
        .reqb_valid(reqb_valid), .reqb_ready(reqb_ready), .reqb_rd(reqb_rd), .reqb_wr(reqb_wr),
        .reqb_waddr(reqb_waddr), .reqb_wdata(reqb_wdata), .reqb_raddr1(reqb_raddr1), .reqb_raddr2(reqb_raddr2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_wr(rf_wr),
        .rf_sel_i1(rf_sel_i1), .rf_sel_o1(rf_sel_o1), .rf_sel_o2(rf_sel_o2),
        .rf_ip1(rf_ip1), .rf_op1(rf_op1), .rf_op2(rf_op2)
    );

    always #5 clk = ~clk;

    // register file: registered read ports, read-before-write on the same edge
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            rf_op1 <= '0;
            rf_op2 <= '0;
        end else if (rf_en) begin
            if (rf_rd) begin
                rf_op1 <= mem[rf_sel_o1];
                rf_op2 <= mem[rf_sel_o2];
            end
            if (rf_wr) mem[rf_sel_i1] <= rf_ip1;
        end
    end

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } cmd_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } exp_t;

    exp_t sb_q[$];
    int   lat_q[$];
    int   acc_ids[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   rf_en_total = 0;
    int   rf_run = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic rd, input logic wr, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.waddr = wa; c.wdata = wd;
        c.ra1 = a1; c.ra2 = a2; c.e1 = e1; c.e2 = e2;
        return c;
    endfunction

    // called on a falling edge; returns on the falling edge after acceptance
    task automatic drive(input bit id, input cmd_t c, input bit keep);
        int   n;
        bit   acc;
        exp_t e;
        if (id) begin
            reqb_rd = c.rd; reqb_wr = c.wr; reqb_waddr = c.waddr; reqb_wdata = c.wdata;
            reqb_raddr1 = c.ra1; reqb_raddr2 = c.ra2; reqb_valid = 1'b1;
        end else begin
            reqa_rd = c.rd; reqa_wr = c.wr; reqa_waddr = c.waddr; reqa_wdata = c.wdata;
            reqa_raddr1 = c.ra1; reqa_raddr2 = c.ra2; reqa_valid = 1'b1;
        end
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 60) begin
            #1;
            if (id ? reqb_ready : reqa_ready) begin
                acc   = 1'b1;
                e.id  = id;
                e.op1 = c.e1;
                e.op2 = c.e2;
                sb_q.push_back(e);
                lat_q.push_back(cyc);
                acc_ids.push_back(int'(id));
                last_acc_cyc = cyc;
            end
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_id%0d", id), {63'd0, acc}, 64'd1);
        if (!keep) begin
            if (id) reqb_valid = 1'b0;
            else    reqa_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        #3;
        while ((sb_q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_id"}, {63'd0, rsp_id}, 64'd0);
        chk({tag, "_rsp_op"}, {rsp_op1, rsp_op2}, 64'd0);
        chk({tag, "_rf_ctl"}, {61'd0, rf_en, rf_rd, rf_wr}, 64'd0);
        chk({tag, "_rf_sel"}, {52'd0, rf_sel_i1, rf_sel_o1, rf_sel_o2}, 64'd0);
        chk({tag, "_rf_ip1"}, {32'd0, rf_ip1}, 64'd0);
        chk({tag, "_ready"}, {62'd0, reqa_ready, reqb_ready}, 64'd0);
    endtask

    // response monitor and per-cycle invariants
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                chk("ready_exclusive", {63'd0, reqa_ready & reqb_ready}, 64'd0);
                if (rf_en) begin
                    rf_run++;
                    rf_en_total++;
                end else if (rf_run != 0) begin
                    chk("rf_en_pulse", 64'(rf_run), 64'd1);
                    rf_run = 0;
                end
                if (rsp_valid && !prev_vld) begin
                    if (lat_q.size() == 0) chk("latency_unexpected", 64'd1, 64'd0);
                    else chk("latency", 64'(cyc - lat_q.pop_front()), 64'd3);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
                        chk("rsp_op1", {32'd0, rsp_op1}, {32'd0, e.op1});
                        chk("rsp_op2", {32'd0, rsp_op2}, {32'd0, e.op2});
                    end
                end
                prev_vld = rsp_valid;
            end else begin
                prev_vld = 1'b0;
                rf_run   = 0;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int en_before;
        int hs;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // write/write/read from A alone
        drive(1'b0, mk(1'b0, 1'b1, 4'd0, 32'hABCDEFAB, 4'd0, 4'd0, 32'h0, 32'h0), 1'b0);
        drive(1'b0, mk(1'b0, 1'b1, 4'd1, 32'h01234567, 4'd0, 4'd0, 32'h0, 32'h0), 1'b0);
        drive(1'b0, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 32'hABCDEFAB, 32'h01234567), 1'b0);
        // write-only: stale register-file outputs must not leak into the acknowledge
        drive(1'b0, mk(1'b0, 1'b1, 4'd3, 32'h11, 4'd0, 4'd1, 32'h0, 32'h0), 1'b0);
        drain();

        // no-op from B; also leaves last grant on B so A leads the contention run
        en_before = rf_en_total;
        drive(1'b1, mk(1'b0, 1'b0, 4'd2, 32'hDEAD, 4'd0, 4'd1, 32'h0, 32'h0), 1'b0);
        drain();
        chk("noop_rf_en", 64'(rf_en_total - en_before), 64'd0);

        // contention
        acc_ids.delete();
        fork
            begin
                drive(1'b0, mk(1'b0, 1'b1, 4'd4, 32'h44, 4'd0, 4'd0, 32'h0, 32'h0), 1'b1);
                drive(1'b0, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd4, 4'd5, 32'h44, 32'h55), 1'b0);
            end
            begin
                drive(1'b1, mk(1'b0, 1'b1, 4'd5, 32'h55, 4'd0, 4'd0, 32'h0, 32'h0), 1'b1);
                drive(1'b1, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd5, 4'd4, 32'h55, 32'h44), 1'b0);
            end
        join
        drain();
        chk("contention_count", 64'(acc_ids.size()), 64'd4);
        if (acc_ids.size() == 4) begin
            chk("contention_order", {32'd0, 8'(acc_ids[0]), 8'(acc_ids[1]), 8'(acc_ids[2]), 8'(acc_ids[3])},
                64'h0000_0000_0001_0001);
        end

        // read+write same register returns old contents, write still lands
        drive(1'b0, mk(1'b1, 1'b1, 4'd3, 32'h22, 4'd3, 4'd3, 32'h11, 32'h11), 1'b0);
        drive(1'b0, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 32'h22, 32'h22), 1'b0);
        drain();

        // backpressure with a B command waiting
        rsp_ready = 1'b0;
        drive(1'b0, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd4, 4'd5, 32'h44, 32'h55), 1'b0);
        hs = 0;
        fork
            drive(1'b1, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd5, 4'd3, 32'h55, 32'h22), 1'b0);
            begin
                int n;
                n = 0;
                #3;
                while (!rsp_valid && n < 20) begin
                    @(negedge clk);
                    #3;
                    n++;
                end
                chk("bp_rsp_seen", {63'd0, rsp_valid}, 64'd1);
                repeat (5) begin
                    @(negedge clk);
                    #3;
                    chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
                    chk("bp_id", {63'd0, rsp_id}, 64'd0);
                    chk("bp_op", {rsp_op1, rsp_op2}, 64'h0000_0044_0000_0055);
                    chk("bp_ready", {62'd0, reqa_ready, reqb_ready}, 64'd0);
                end
                @(negedge clk);
                rsp_ready = 1'b1;
                #3;
                hs = cyc;
            end
        join
        chk("bp_reaccept", 64'(last_acc_cyc - hs), 64'd1);
        drain();

        // reset while a read is in EXEC
        drive(1'b0, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 32'hABCDEFAB, 32'h01234567), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk_all_zero("midrst");
        sb_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        chk("midrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);

        // after reset A must win the tie again
        acc_ids.delete();
        fork
            drive(1'b0, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 32'hABCDEFAB, 32'h01234567), 1'b0);
            drive(1'b1, mk(1'b1, 1'b0, 4'd0, 32'h0, 4'd4, 4'd5, 32'h44, 32'h55), 1'b0);
        join
        drain();
        chk("postrst_count", 64'(acc_ids.size()), 64'd2);
        if (acc_ids.size() == 2) begin
            chk("postrst_order", {48'd0, 8'(acc_ids[0]), 8'(acc_ids[1])}, 64'h0000_0000_0000_0001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the 16x32 register file's single command port (EN/RD/WR, one write select, two read selects) between two requesters, A and B.
- Accepts one command at a time through a valid/ready handshake. Arbitration is round-robin.
- Drives registered control signals into the register file, then returns the read data (or a write acknowledge) to the granted requester over a shared response channel.
- Sits between the decode/issue logic and the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register select width (2**ADDR_W registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- reqa_valid / reqb_valid  in  1  command present
- reqa_ready / reqb_ready  out  1  command accepted this cycle
- reqa_rd / reqb_rd  in  1  read request
- reqa_wr / reqb_wr  in  1  write request
- reqa_waddr / reqb_waddr  in  ADDR_W  write select
- reqa_wdata / reqb_wdata  in  DATA_W  write data
- reqa_raddr1 / reqb_raddr1  in  ADDR_W  read select 1
- reqa_raddr2 / reqb_raddr2  in  ADDR_W  read select 2
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_id  out  1  0 = requester A, 1 = requester B
- rsp_op1 / rsp_op2  out  DATA_W  read data (zero for write-only and no-op commands)
- rf_en, rf_rd, rf_wr  out  1  register-file control
- rf_sel_i1, rf_sel_o1, rf_sel_o2  out  ADDR_W  register-file selects
- rf_ip1  out  DATA_W  register-file write data
- rf_op1 / rf_op2  in  DATA_W  register-file read outputs (registered inside the register file)

Behaviour:
- Reset:
  - Every output is 0.
  - State = IDLE.
  - last_grant = B, so A wins the first tie.
  - The arbiter does not reset the register file; the top level routes rst to both blocks.
- States: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - reqX_ready is driven combinationally and is high only for the selected requester.
  - Selection: if only one requester is valid, select it. If both are valid, select the one that is not last_grant.
  - On the accepting edge (E0):
    - Latch the granted command's fields.
    - Register rf_en = rd|wr, rf_rd = rd, rf_wr = wr, and the selects/data from the granted requester.
    - Update last_grant and rsp_id.
    - Next state = EXEC.
- EXEC (one cycle):
  - rf_* are stable; the register file acts on edge E1.
  - At E1: rf_en, rf_rd, rf_wr <= 0. Next state = WAIT.
- WAIT (one cycle):
  - At E2: rsp_op1/rsp_op2 <= rf_op1/rf_op2 if the latched rd = 1, else 0.
  - At E2: rsp_valid <= 1. Next state = RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid = 1 and rsp_ready = 0.
  - On an edge where rsp_ready = 1: rsp_valid <= 0, next state = IDLE.
  - A new command is not accepted in that same cycle.
- Latency: 3 cycles from acceptance to rsp_valid, minimum. Maximum throughput is one command per 4 cycles.
- Both reqX_ready are 0 in EXEC, WAIT and RESP. There is only ever one outstanding command.
- Command with rd = 1 and wr = 1: the read returns the pre-write contents, per register-file semantics. The write still lands.
- Command with rd = 0 and wr = 0: it is accepted, rf_en stays 0, and it is acknowledged with zero data.
- Requester valid is not required to be held after a refused cycle. Only the fields present on the accepting edge are used.
- Reset mid-operation:
  - Abandon the in-flight command. rf_en is 0 from the reset edge onward.
  - A write already sampled by the register file at E1 is not undone.
  - Any pending response is dropped.
- Fairness: with both requesters continuously valid, grants alternate A, B, A, B, and neither waits more than one command.

Test Plan:
- Write then read, single requester: reset 2 cycles, then A writes 0xABCDEFAB to reg 0; A writes 0x01234567 to reg 1; A reads raddr1 = 0, raddr2 = 1. Required: third response has rsp_id = 0, rsp_op1 = 0xABCDEFAB, rsp_op2 = 0x01234567; each rsp_valid occurs 3 cycles after acceptance.
- Contention: A and B both valid every cycle for 4 commands. Required: accept order A, B, A, B; reqa_ready and reqb_ready are never high together; rf_en pulses exactly 1 cycle per command.
- Backpressure: rsp_ready held 0 for 5 cycles. Required: rsp_* stable, both reqX_ready = 0; after rsp_ready = 1, return to IDLE and accept on the following cycle.
- Simultaneous read+write to reg 3 (old value 0x11, new value 0x22). Required: response rsp_op1 = 0x11; a subsequent read returns 0x22.
- No-op and write-only commands: no-op gives rf_en = 0 throughout and rsp_op1 = rsp_op2 = 0; write-only gives a zero-data acknowledge.
- Reset asserted during EXEC of a read: next cycle all outputs are 0 and state is IDLE, with no response issued; after release, A is granted first on contention.
